fetch_sequencer: RTL and testbench

//  Owns the architectural PC and sequences instruction fetch for the IF stage.

---
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and single-outstanding instruction fetch sequencer for the IF stage
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              if_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr,
    output logic              pc_misalign
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              pend_valid_q, pend_valid_d;
    logic              kill_q, kill_d;
    logic              if_valid_q, if_valid_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] target_aligned;

    assign target_aligned = {redirect_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        kill_d        = kill_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        misalign_d    = misalign_q;

        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    if (imem_ack) begin
                        pc_d         = target_aligned;
                        kill_d       = 1'b0;
                        pend_valid_d = 1'b0;
                    end else begin
                        // Address must stay stable until ack, so park the target.
                        kill_d        = 1'b1;
                        pend_target_d = target_aligned;
                        pend_valid_d  = 1'b1;
                    end
                end else if (imem_ack && kill_q) begin
                    pc_d         = pend_target_q;
                    kill_d       = 1'b0;
                    pend_valid_d = 1'b0;
                    if (if_valid_q && !if_stall) begin
                        if_valid_d = 1'b0;
                    end
                end else if (imem_ack) begin
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rdata;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = if_stall ? HOLD : FETCH;
                end else if (if_valid_q && !if_stall) begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = target_aligned;
                    state_d    = FETCH;
                end else if (!if_stall) begin
                    if_valid_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase

        if (state_q != BOOT && redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
            kill_q        <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            kill_q        <= kill_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign pc_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - table-driven directed bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        pc_misalign;

    int checks = 0;
    int errors = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_stall       (if_stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .pc_misalign    (pc_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rst;
        logic        rv;
        logic [31:0] rt;
        logic        st;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] iw(input logic [31:0] a);
        return {8'hC0, a[23:0]};
    endfunction

    task automatic add(input logic chk, input logic r, input logic rv, input logic [31:0] rt,
                       input logic st, input logic ack, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_mis);
        vec_t v;
        v.chk = chk; v.rst = r; v.rv = rv; v.rt = rt; v.st = st; v.ack = ack; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic e_req, input logic [31:0] e_addr,
                              input logic e_v, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic e_mis);
        cmp("imem_req", idx, {31'd0, imem_req}, {31'd0, e_req});
        cmp("imem_addr", idx, imem_addr, e_addr);
        cmp("if_valid", idx, {31'd0, if_valid}, {31'd0, e_v});
        cmp("if_pc", idx, if_pc, e_pc);
        cmp("if_instr", idx, if_instr, e_instr);
        cmp("pc_misalign", idx, {31'd0, pc_misalign}, {31'd0, e_mis});
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rt,
                         input logic st, input logic ack, input logic [31:0] rd);
        rst = r; redirect_valid = rv; redirect_target = rt;
        if_stall = st; imem_ack = ack; imem_rdata = rd;
    endtask

    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    initial begin
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // chk rst rv rt st ack rd | req addr v pc instr mis
        add(0, 1, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0,              0, 32'h3000, 0, 0, 0, 0);
        // back-to-back fetches
        add(1, 0, 0, 0, 0, 1, iw(32'h3000),   1, 32'h3000, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, iw(32'h3004),   1, 32'h3004, 1, 32'h3000, iw(32'h3000), 0);
        add(1, 0, 0, 0, 0, 1, iw(32'h3008),   1, 32'h3008, 1, 32'h3004, iw(32'h3004), 0);
        // delayed ack: address held, word consumed once
        add(1, 0, 0, 0, 0, 0, 0,              1, 32'h300C, 1, 32'h3008, iw(32'h3008), 0);
        add(1, 0, 0, 0, 0, 0, 0,              1, 32'h300C, 0, 32'h3008, iw(32'h3008), 0);
        add(1, 0, 0, 0, 0, 0, 0,              1, 32'h300C, 0, 32'h3008, iw(32'h3008), 0);
        // capture with stall -> HOLD
        add(1, 0, 0, 0, 1, 1, iw(32'h300C),   1, 32'h300C, 0, 32'h3008, iw(32'h3008), 0);
        add(1, 0, 0, 0, 1, 0, 0,              0, 32'h3010, 1, 32'h300C, iw(32'h300C), 0);
        add(1, 0, 0, 0, 1, 1, DEAD,           0, 32'h3010, 1, 32'h300C, iw(32'h300C), 0);
        add(1, 0, 0, 0, 1, 0, 0,              0, 32'h3010, 1, 32'h300C, iw(32'h300C), 0);
        add(1, 0, 0, 0, 1, 0, 0,              0, 32'h3010, 1, 32'h300C, iw(32'h300C), 0);
        add(1, 0, 0, 0, 0, 0, 0,              0, 32'h3010, 1, 32'h300C, iw(32'h300C), 0);
        // redirect with fetch in flight, ack two cycles later
        add(1, 0, 1, 32'h3100, 0, 0, 0,       1, 32'h3010, 0, 32'h300C, iw(32'h300C), 0);
        add(1, 0, 0, 0, 0, 0, 0,              1, 32'h3010, 0, 32'h300C, iw(32'h300C), 0);
        add(1, 0, 0, 0, 0, 1, DEAD,           1, 32'h3010, 0, 32'h300C, iw(32'h300C), 0);
        add(1, 0, 0, 0, 0, 1, iw(32'h3100),   1, 32'h3100, 0, 32'h300C, iw(32'h300C), 0);
        // misaligned redirect in flight, then redirect+ack+kill (latest wins)
        add(1, 0, 1, 32'h3202, 0, 0, 0,       1, 32'h3104, 1, 32'h3100, iw(32'h3100), 0);
        add(1, 0, 1, 32'h3300, 0, 1, DEAD,    1, 32'h3104, 0, 32'h3100, iw(32'h3100), 1);
        add(1, 0, 0, 0, 0, 1, iw(32'h3300),   1, 32'h3300, 0, 32'h3100, iw(32'h3100), 1);
        // redirect+ack with no kill, misaligned target forced to 0x3100
        add(1, 0, 1, 32'h3102, 0, 1, DEAD,    1, 32'h3304, 1, 32'h3300, iw(32'h3300), 1);
        add(1, 0, 0, 0, 1, 1, iw(32'h3100),   1, 32'h3100, 0, 32'h3300, iw(32'h3300), 1);
        // redirect in HOLD ignores stall
        add(1, 0, 1, 32'h3400, 1, 0, 0,       0, 32'h3104, 1, 32'h3100, iw(32'h3100), 1);
        add(1, 0, 0, 0, 1, 0, 0,              1, 32'h3400, 0, 32'h3100, iw(32'h3100), 1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rv, vecs[i].rt, vecs[i].st, vecs[i].ack, vecs[i].rd);
            if (vecs[i].chk) begin
                check_outs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_v,
                           vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_mis);
            end
            @(negedge clk);
        end

        // reset mid-fetch with kill pending: no stale capture, misalign cleared
        drive(1'b0, 1'b1, 32'h3500, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, DEAD);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_outs(100, 1'b0, 32'h3000, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, iw(32'h3000));
        check_outs(101, 1'b1, 32'h3000, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_outs(102, 1'b1, 32'h3004, 1'b1, 32'h3000, iw(32'h3000), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
